// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage execution unit.
// Executes add/sub/and/or in one cycle and a WIDTH-cycle iterative
// shift-add multiply (low word). A start/busy/valid handshake lets the
// control unit stall the pipeline while a multiply is in flight.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   start_i    request to execute ALUCtrl_i on data1_i/data2_i
//   ALUCtrl_i  001 add, 010 sub, 011 and, 100 or, 101 mul, others invalid
//   data1_i    operand A (multiplicand)
//   data2_i    operand B (multiplier)
//   data_o     registered result, held until the next result is written
//   zero_o     registered, 1 when the last written data_o is 0
//   busy_o     high while a multiply is in progress; requests are refused
//   valid_o    one-cycle pulse after data_o/zero_o were written
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             valid_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q,  mplr_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic               zero_q,  zero_d;
  logic               busy_q,  busy_d;
  logic               valid_q, valid_d;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc_step;

  // Single-cycle datapath; invalid codes (and mul, unused here) yield 0.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_AND:  alu_res = data1_i & data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      default: alu_res = '0;
    endcase
  end

  // One shift-add iteration: conditionally add the shifted multiplicand.
  always_comb begin
    acc_step = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand_d = data1_i;
            mplr_d  = data2_i;
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            busy_d  = 1'b1;
            state_d = S_MUL;
          end else begin
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
            valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q - CNT_W'(1);
        // Last iteration: publish the accumulator including this step.
        if (cnt_q == CNT_W'(1)) begin
          data_d  = acc_step;
          zero_d  = (acc_step == '0);
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, multiply latency
// and corner sequences, and randomized ops against a behavioural model.
module tb_alu_mc;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] data;
  logic         zero, busy, valid;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] last;

  alu_mc #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ALUCtrl_i(op),
    .data1_i(a), .data2_i(b),
    .data_o(data), .zero_o(zero), .busy_o(busy), .valid_o(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: product computed at full width, low word kept.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      3'd1: return x + y;
      3'd2: return x - y;
      3'd3: return x & y;
      3'd4: return x | y;
      3'd5: return p[W-1:0];
      default: return '0;
    endcase
  endfunction

  // Advance one edge, sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one single-cycle op; start stays high for the caller to chain.
  task automatic single(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    chk("single_valid", W'(valid), W'(1));
    chk("single_busy", W'(busy), W'(0));
    chk("single_data", data, exp);
    chk("single_zero", W'(zero), W'(exp == '0));
    last = exp;
  endtask

  // Idle cycles: no pulse, result held.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; op = 3'(($urandom % 8));
      tick();
      chk("idle_valid", W'(valid), W'(0));
      chk("idle_busy", W'(busy), W'(0));
      chk("idle_data", data, last);
    end
  endtask

  // Full multiply: accept edge 0, busy for edges 1..31, result at edge 32.
  // poke=1 tries an add while busy and scrambles the operand inputs.
  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    logic [W-1:0] exp;
    exp = model(3'd5, x, y);
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = x; b = y;
    tick();
    chk("mul_accept_busy", W'(busy), W'(1));
    chk("mul_accept_valid", W'(valid), W'(0));
    for (int k = 1; k < W; k++) begin
      @(negedge clk);
      if (poke && k >= 5 && k <= 7) begin
        start = 1'b1; op = 3'd1; a = 1; b = 1;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
      tick();
      if (busy !== 1'b1 || valid !== 1'b0 || data !== last) begin
        chk("mul_inflight_busy", W'(busy), W'(1));
        chk("mul_inflight_valid", W'(valid), W'(0));
        chk("mul_inflight_data", data, last);
      end else begin
        tests++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    tick();
    chk("mul_done_valid", W'(valid), W'(1));
    chk("mul_done_busy", W'(busy), W'(0));
    chk("mul_data", data, exp);
    chk("mul_zero", W'(zero), W'(exp == '0));
    last = exp;
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; start = 1'b1; op = 3'd1; a = 7; b = 5;
    last = '0;

    // Reset held two cycles with a pending request.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_data", data, 0);
      chk("rst_zero", W'(zero), W'(1));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_valid", W'(valid), W'(0));
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    idle(2);

    // Back-to-back single-cycle vectors.
    vecs.push_back('{3'd1, 32'd7,        32'd5,        32'd12});
    vecs.push_back('{3'd2, 32'd5,        32'd7,        32'hFFFF_FFFE});
    vecs.push_back('{3'd3, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0});
    vecs.push_back('{3'd4, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F});
    vecs.push_back('{3'd2, 32'd9,        32'd9,        32'd0});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'd1,        32'd0});
    vecs.push_back('{3'd1, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678});
    vecs.push_back('{3'd7, 32'd5,        32'd3,        32'd0});
    vecs.push_back('{3'd4, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A});
    vecs.push_back('{3'd0, 32'd5,        32'd3,        32'd0});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001});
    vecs.push_back('{3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0});
    foreach (vecs[i]) single(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    idle(2);

    // Multiply latency/value corners.
    do_mul(32'd1234, 32'd5678, 1'b0);
    chk("mul_1234x5678", data, 32'd7006652);
    idle(1);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mul_ones", data, 32'd1);
    idle(1);
    do_mul(32'd0, 32'h0000_ABCD, 1'b0);
    chk("mul_zero_flag", W'(zero), W'(1));
    idle(1);

    // Refused request while busy; exactly one pulse afterwards.
    do_mul(32'd300, 32'd7, 1'b1);
    chk("mul_refused_add", data, 32'd2100);
    idle(3);

    // Handoff: add accepted in the cycle the mul pulse is high.
    do_mul(32'd6, 32'd7, 1'b0);
    single(3'd1, 32'd1, 32'd2, 32'd3);
    idle(1);

    // Reset at edge 10 of a multiply.
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd1234; b = 32'd5678;
    tick();
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_data", data, 0);
    chk("midrst_zero", W'(zero), W'(1));
    chk("midrst_valid", W'(valid), W'(0));
    @(negedge clk);
    rst = 1'b0;
    last = '0;
    idle(30);
    single(3'd1, 32'd2, 32'd3, 32'd5);
    idle(1);

    // Randomized ops against the model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom % 4 == 0) ? W'($urandom % 16) : $urandom;
      if (ro == 3'd5) do_mul(ra, rb, ($urandom % 2) == 1);
      else            single(ro, ra, rb, model(ro, ra, rb));
      if ($urandom % 3 == 0) idle(1);
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle execution unit that consumes the 3-bit ALU control code produced by the CPU's ALU control decoder.
- Performs add, sub, and, or in one cycle, and a 32-cycle iterative shift-add multiply (low-word result).
- Sits in the EX stage between the register-file read operands and the write-back path.
- Uses a start/busy/valid handshake so the control unit can stall the pipeline while a multiply is in flight.

Parameters:
- WIDTH, 32, operand and result width in bits; the multiply iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  request to execute ALUCtrl_i on data1_i/data2_i.
- ALUCtrl_i  input  3  operation code: 001 add, 010 sub, 011 and, 100 or, 101 mul, all others invalid.
- data1_i  input  WIDTH  operand A (multiplicand for mul).
- data2_i  input  WIDTH  operand B (multiplier for mul).
- data_o  output  WIDTH  registered result; holds its value until the next result is written.
- zero_o  output  1  registered; 1 when the most recently written data_o is 0.
- busy_o  output  1  1 while a multiply is in progress; requests are refused while high.
- valid_o  output  1  one-cycle pulse marking that data_o/zero_o were updated in the previous edge.

Behaviour:
- Reset:
  - rst_i=1 sampled at an edge forces data_o=0, zero_o=1, busy_o=0, valid_o=0.
  - It also forces state IDLE and clears all internal registers.
  - Reset has priority over start_i and aborts an in-flight multiply; no valid_o pulse is produced for the aborted operation.
- Accept rule:
  - A request is accepted at an edge where start_i=1 and busy_o=0.
  - start_i while busy_o=1 is ignored; it is neither queued nor allowed to corrupt the multiply.
  - Operands and ALUCtrl_i are sampled only at the accept edge and may change afterwards.
- States: IDLE, MUL.
- IDLE, on accept with a single-cycle op:
  - data_o <= result and zero_o <= (result==0) at the same edge; valid_o=1 for exactly the following cycle.
  - State stays IDLE, so back-to-back single-cycle requests every cycle are legal and each yields one valid_o pulse.
- IDLE, on accept with 101 (mul):
  - Load mcand=data1_i, mplr=data2_i, acc=0, cnt=WIDTH; busy_o=1 from the next cycle; go to MUL.
  - valid_o stays 0 that cycle.
- MUL, each edge:
  - If mplr[0], acc <= acc + mcand (mod 2^WIDTH).
  - Then mcand <<= 1, mplr >>= 1, cnt -= 1.
  - At the edge where cnt==1: data_o <= final acc, zero_o updated, valid_o=1 next cycle, busy_o=0, go to IDLE.
- Multiply latency:
  - Fixed at WIDTH edges from accept to result; no early termination, even for zero operands.
  - A new request can be accepted in the cycle valid_o is high, because busy_o is already 0.
- Arithmetic:
  - Add and sub wrap modulo 2^WIDTH; no carry or overflow output.
  - Mul returns the low WIDTH bits of the product, which are identical for signed and unsigned operands.
- Invalid codes (000, 110, 111): treated as single-cycle; data_o <= 0, zero_o <= 1, valid_o pulses.
- Without an accept, data_o and zero_o hold their values and valid_o=0.

Test Plan:
- Reset: hold rst_i for 2 cycles with start_i=1, ALUCtrl_i=001 -> data_o=0, zero_o=1, busy_o=0, valid_o=0 throughout; release -> still idle with no pulse.
- Single-cycle ops, back-to-back:
  - add 7+5 -> 12; sub 5-7 -> 0xFFFFFFFE; and 0xF0F0 & 0x0FF0 -> 0x00F0; or 0xF000 | 0x000F -> 0xF00F.
  - Issue on 4 consecutive cycles -> 4 consecutive valid_o pulses, each one cycle after its request; sub 9-9 -> data_o=0, zero_o=1.
- Multiply latency and value:
  - mul 1234 x 5678 accepted at edge 0 -> busy_o high edges 1..31, data_o=7006652 with valid_o high after edge 32.
  - mul 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001; mul 0 x 0xABCD -> 0, zero_o=1, same 32-edge latency.
- Busy refusal: during a multiply assert start_i with add 1+1 -> ignored; final result unchanged; exactly one valid_o pulse.
- Reset mid-operation: assert rst_i at edge 10 of a multiply -> busy_o=0, data_o=0, no valid_o; a subsequent add 2+3 -> 5 in one cycle.
- Invalid code and handoff:
  - ALUCtrl_i=111 -> data_o=0, zero_o=1, valid_o pulse.
  - Issue add 1+2 in the cycle mul valid_o is high -> accepted; 3 appears on the next valid_o.
